// File: rtl/fetch_inst_queue.sv
// Instruction queue between fetch and decode: a circular FIFO of {pc, inst}
// pairs with show-ahead output, full backpressure and flush on redirect.
module fetch_inst_queue #(
    parameter int ADDR  = 32,
    parameter int INST  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            flush,
    input  logic            in_e_,
    input  logic [ADDR-1:0] in_pc,
    input  logic [INST-1:0] in_inst,
    output logic            in_busy,
    output logic            out_e_,
    output logic [ADDR-1:0] out_pc,
    output logic [INST-1:0] out_inst,
    input  logic            dec_stall
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = ADDR + INST;

    logic [EW-1:0] storage_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          in_busy_r;
    logic          out_e_r;
    logic [EW-1:0] head_r;

    logic          full_s;
    logic          wr_s;
    logic          rd_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [EW-1:0] head_nxt_s;

    assign full_s = (count_r == CW'(DEPTH));
    assign wr_s   = !in_e_ && !full_s && !flush;
    assign rd_s   = !out_e_r && !dec_stall && !flush;

    // Next-state pointers, occupancy and the entry that will be at the head.
    // The head is pre-computed so every output leaves a flop; when the slot
    // being written this cycle becomes the head, take the incoming data.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = {EW{1'b0}};
        if (flush) begin
            wr_ptr_nxt_s = {PW{1'b0}};
            rd_ptr_nxt_s = {PW{1'b0}};
            count_nxt_s  = {CW{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            count_nxt_s = count_r + CW'(wr_s) - CW'(rd_s);
        end
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = {EW{1'b0}};
        end else if (wr_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = {in_pc, in_inst};
        end else begin
            head_nxt_s = storage_r[rd_ptr_nxt_s];
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            in_busy_r <= 1'b0;
            out_e_r   <= 1'b1;
            head_r    <= {EW{1'b0}};
        end else begin
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            in_busy_r <= (count_nxt_s == CW'(DEPTH));
            out_e_r   <= (count_nxt_s == {CW{1'b0}});
            head_r    <= head_nxt_s;
        end
    end

    // Entry storage; contents are don't-care out of reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            storage_r[wr_ptr_r] <= {in_pc, in_inst};
        end else begin
            storage_r[wr_ptr_r] <= storage_r[wr_ptr_r];
        end
    end

    assign in_busy  = in_busy_r;
    assign out_e_   = out_e_r;
    assign out_pc   = head_r[EW-1:INST];
    assign out_inst = head_r[INST-1:0];

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Instruction queue between the fetch stage output and the decoder input.
- Captures each valid fetched instruction and its PC into a small circular FIFO. Presents the oldest entry to decode in show-ahead form.
- Absorbs decode stalls and asserts backpressure to fetch when full.
- Flush discards all buffered instructions on a pipeline redirect.

Parameters:
- ADDR, 32, PC width in bits.
- INST, 32, instruction width in bits.
- DEPTH, 4, number of entries. Must be a power of two, minimum 2.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset_  input  1  asynchronous active-low reset.
- flush  input  1  active-high; discards all queue contents.
- in_e_  input  1  active-low valid from fetch (fetch inst_e_).
- in_pc  input  ADDR  PC of the incoming instruction.
- in_inst  input  INST  incoming instruction word.
- in_busy  output  1  active-high backpressure to fetch; queue full.
- out_e_  output  1  active-low valid to decode; low when the queue is non-empty.
- out_pc  output  ADDR  PC of the oldest entry.
- out_inst  output  INST  oldest instruction word.
- dec_stall  input  1  active-high; decode cannot accept this cycle.

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset_ is asynchronous and active-low; the team's clock/reset convention applies (clk, reset_).
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - out_e_ = 1, in_busy = 0, out_pc = 0, out_inst = 0.
  - Storage array contents are don't-care.
- State:
  - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count is log2(DEPTH)+1 bits wide, range 0..DEPTH.
- Derived signals:
  - full = (count == DEPTH).
  - empty = (count == 0).
  - in_busy = full. It depends only on registered count, with no combinational path from dec_stall or in_e_.
  - out_e_ = empty.
  - out_pc / out_inst = storage[rd_ptr] when not empty, forced to 0 when empty.
- Write and read conditions:
  - wr = !in_e_ && !full && !flush.
  - rd = !out_e_ && !dec_stall && !flush.
- Update on each clk edge (when not flushing):
  - On wr: storage[wr_ptr] <= {in_pc, in_inst}; wr_ptr <= wr_ptr + 1.
  - On rd: rd_ptr <= rd_ptr + 1.
  - count <= count + wr - rd.
  - Simultaneous wr and rd: count is unchanged and both pointers advance.
- Latency:
  - A write at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
  - Maximum throughput is one instruction per cycle in steady state.
- Full boundary:
  - When full, any in_e_=0 from fetch is ignored and not stored. Fetch is required to hold its instruction while in_busy=1.
  - A read in the same cycle while full does not enable the write. in_busy deasserts in the next cycle.
- Empty boundary:
  - dec_stall is irrelevant when empty.
  - No read occurs and the pointers hold.
- Flush:
  - Has priority over all other events.
  - Next edge: wr_ptr = rd_ptr = 0, count = 0.
  - A same-cycle incoming instruction is dropped and a same-cycle read is not counted.
  - Following the flush edge: out_e_ = 1, in_busy = 0.
- Mid-operation reset:
  - Asserting reset_ immediately forces all reset values (asynchronously), regardless of clk.
- Ordering:
  - Strict FIFO order. PC and instruction pairing is preserved per entry.

Test Plan:
- Fill and drain:
  - Stimulus: dec_stall=1; push PCs 0x1000, 0x1004, 0x1008, 0x100C.
  - Required: in_busy=1 after the 4th edge; 5th push (0x1010) is ignored.
  - Stimulus: release dec_stall.
  - Required: out_pc sequence 0x1000, 0x1004, 0x1008, 0x100C over 4 cycles, then out_e_=1.
- Streaming:
  - Stimulus: continuous pushes with dec_stall=0.
  - Required: each instruction appears on out_* exactly one cycle after its push; count stays at 1; in_busy stays 0.
- Full with simultaneous read:
  - Stimulus: queue full; in_e_=0 and dec_stall=0 in the same cycle.
  - Required: oldest entry is consumed; new instruction is not stored; count=3; in_busy=0 next cycle.
- Flush:
  - Stimulus: 3 entries held; flush=1 with in_e_=0 (PC 0x2000).
  - Required: after the edge, out_e_=1, count=0, and 0x2000 is absent.
  - Stimulus: next push of PC 0x3000.
  - Required: 0x3000 appears as the oldest entry.
- Wrap-around:
  - Stimulus: push and pop 10 instructions in mixed stall patterns.
  - Required: pointers wrap past 3→0; output order and PC/instruction pairing are intact.
- Async reset:
  - Stimulus: assert reset_=0 between clock edges with 2 entries held.
  - Required: out_e_=1, in_busy=0, out_pc=0 immediately, without waiting for clk.
